// File: rtl/sbox_share_ctrl.sv
// -----------------------------------------------------------------------------
// sbox_share_ctrl
//
// Arbitrates one external 4-lane AES S-box between two requesters:
//   * the round datapath (SubBytes on a 128-bit state, issued as 4 beats of
//     4 bytes), and
//   * the key expansion (SubWord on a 32-bit word, issued as a single beat).
// Each requester has its own one-entry output buffer. A requester is only
// eligible while its buffer is empty, so a stalled consumer on one side never
// blocks the other side. A granted job always runs to completion.
//
// Parameters
//   SBOX_LAT        register stages inside the external S-box (0..2)
//
// Build option
//   SBOX_SHARE_FAIR_EN  when defined, simultaneous requests are served
//                       round-robin; otherwise the key requester always wins.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   data_in_valid/ready, data_in  SubBytes request (128-bit state)
//   data_encrypt                  1 = forward S-box, 0 = inverse
//   data_out_valid/ready,data_out SubBytes result
//   key_in_valid/ready, key_in    SubWord request (32-bit word)
//   key_out_valid/ready, key_out  SubWord result
//   sbox_in, sbox_encrypt         lane inputs / mode to the shared S-box
//   sbox_out                      lane results, SBOX_LAT cycles after sbox_in
// -----------------------------------------------------------------------------
module sbox_share_ctrl #(
    parameter int SBOX_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         data_in_valid,
    output logic         data_in_ready,
    input  logic [127:0] data_in,
    input  logic         data_encrypt,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic [127:0] data_out,

    input  logic         key_in_valid,
    output logic         key_in_ready,
    input  logic [31:0]  key_in,
    output logic         key_out_valid,
    input  logic         key_out_ready,
    output logic [31:0]  key_out,

    output logic [31:0]  sbox_in,
    output logic         sbox_encrypt,
    input  logic [31:0]  sbox_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Depth of the capture-tag pipeline; at least one stage so the arrays are
    // always legal even when the S-box is purely combinational.
    localparam int PIPE_DEPTH = (SBOX_LAT > 0) ? SBOX_LAT : 1;
    localparam logic [1:0] DRAIN_LAST = 2'((SBOX_LAT > 0) ? SBOX_LAT - 1 : 0);

    state_t        state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;       // beat index in ISSUE, drain count in DRAIN

    logic          job_key_reg;             // current job belongs to key expansion
    logic          mode_reg;                // S-box direction for the current job
    logic [127:0]  payload_reg;             // request payload captured at accept

    logic          key_elig, data_elig, in_idle;
    logic          grant_key, grant_data;
    logic          issue_valid, last_beat;

    // Tags travelling alongside the S-box pipeline so each result lands in
    // the right buffer slice when it emerges.
    logic          pipe_valid_reg [PIPE_DEPTH];
    logic          pipe_key_reg   [PIPE_DEPTH];
    logic [1:0]    pipe_beat_reg  [PIPE_DEPTH];
    logic          cap_valid, cap_key;
    logic [1:0]    cap_beat;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign key_elig  = key_in_valid  && !key_out_valid;
    assign data_elig = data_in_valid && !data_out_valid;
    // rst_n gates the grant so no ready is shown while reset is held.
    assign in_idle   = rst_n && (state_reg == IDLE);

`ifdef SBOX_SHARE_FAIR_EN
    logic prio_key_reg;                     // 1: key wins the next tie

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_key_reg <= 1'b1;
        end else if (grant_key) begin
            prio_key_reg <= 1'b0;
        end else if (grant_data) begin
            prio_key_reg <= 1'b1;
        end
    end

    assign grant_key  = in_idle && key_elig  && (!data_elig || prio_key_reg);
    assign grant_data = in_idle && data_elig && (!key_elig  || !prio_key_reg);
`else
    assign grant_key  = in_idle && key_elig;
    assign grant_data = in_idle && data_elig && !key_elig;
`endif

    assign key_in_ready  = grant_key;
    assign data_in_ready = grant_data;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign issue_valid = (state_reg == ISSUE);
    assign last_beat   = job_key_reg || (cnt_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant_key || grant_data) begin
                    state_next = ISSUE;
                    cnt_next   = 2'd0;
                end
            end
            ISSUE: begin
                if (last_beat) begin
                    cnt_next   = 2'd0;
                    state_next = (SBOX_LAT == 0) ? IDLE : DRAIN;
                end else begin
                    cnt_next   = cnt_reg + 2'd1;
                end
            end
            DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 2'd0;
                end else begin
                    cnt_next   = cnt_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // S-box drive: zero when no beat is issued, forward mode when idle.
    always_comb begin
        sbox_in      = 32'd0;
        sbox_encrypt = 1'b1;
        if (issue_valid) begin
            sbox_encrypt = mode_reg;
            if (job_key_reg) begin
                sbox_in = payload_reg[31:0];
            end else begin
                sbox_in = payload_reg[{cnt_reg, 5'd0} +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request capture at accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_key_reg <= 1'b0;
            mode_reg    <= 1'b1;
            payload_reg <= 128'd0;
        end else if (grant_key) begin
            job_key_reg <= 1'b1;
            mode_reg    <= 1'b1;            // key expansion always uses forward S-box
            payload_reg <= {96'd0, key_in};
        end else if (grant_data) begin
            job_key_reg <= 1'b0;
            mode_reg    <= data_encrypt;
            payload_reg <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Result tag pipeline, matched to the S-box latency
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_key_reg[i]   <= 1'b0;
                pipe_beat_reg[i]  <= 2'd0;
            end
        end else begin
            pipe_valid_reg[0] <= issue_valid;
            pipe_key_reg[0]   <= job_key_reg;
            pipe_beat_reg[0]  <= cnt_reg;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_key_reg[i]   <= pipe_key_reg[i-1];
                pipe_beat_reg[i]  <= pipe_beat_reg[i-1];
            end
        end
    end

    // With a combinational S-box the result is captured in the issue cycle.
    assign cap_valid = (SBOX_LAT == 0) ? issue_valid : pipe_valid_reg[PIPE_DEPTH-1];
    assign cap_key   = (SBOX_LAT == 0) ? job_key_reg : pipe_key_reg[PIPE_DEPTH-1];
    assign cap_beat  = (SBOX_LAT == 0) ? cnt_reg     : pipe_beat_reg[PIPE_DEPTH-1];

    // ------------------------------------------------------------------
    // Output buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_valid <= 1'b0;
            data_out       <= 128'd0;
            key_out_valid  <= 1'b0;
            key_out        <= 32'd0;
        end else begin
            if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
            if (key_out_valid && key_out_ready) begin
                key_out_valid <= 1'b0;
            end
            // A capture only happens for a job whose buffer was empty at
            // grant, so it never collides with a pending handshake.
            if (cap_valid) begin
                if (cap_key) begin
                    key_out       <= sbox_out;
                    key_out_valid <= 1'b1;
                end else begin
                    data_out[{cap_beat, 5'd0} +: 32] <= sbox_out;
                    if (cap_beat == 2'd3) begin
                        data_out_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
module tb_sbox_share_ctrl;

    localparam logic [127:0] INC_STATE = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] FWD_EXP   = 128'h76ABD7FE2B670130C56F6BF27B777C63;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- GF(2^8) S-box reference for the external S-box ----------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x, input logic enc);
        logic [7:0] b;
        if (enc) begin
            b = ginv(x);
            return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w, input logic enc);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_byte(w[8*j +: 8], enc);
        return r;
    endfunction

    // ---------------- DUT 1: SBOX_LAT = 0 ----------------
    logic         d_in_valid, d_in_ready, d_enc, d_out_valid, d_out_ready;
    logic [127:0] d_in, d_out;
    logic         k_in_valid, k_in_ready, k_out_valid, k_out_ready;
    logic [31:0]  k_in, k_out, s_in, s_out;
    logic         s_enc;

    assign s_out = sbox_word(s_in, s_enc);

    sbox_share_ctrl #(.SBOX_LAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .data_in_valid(d_in_valid), .data_in_ready(d_in_ready), .data_in(d_in),
        .data_encrypt(d_enc), .data_out_valid(d_out_valid),
        .data_out_ready(d_out_ready), .data_out(d_out),
        .key_in_valid(k_in_valid), .key_in_ready(k_in_ready), .key_in(k_in),
        .key_out_valid(k_out_valid), .key_out_ready(k_out_ready), .key_out(k_out),
        .sbox_in(s_in), .sbox_encrypt(s_enc), .sbox_out(s_out)
    );

    // ---------------- DUT 2: SBOX_LAT = 2 ----------------
    logic         d2_in_valid, d2_in_ready, d2_enc, d2_out_valid, d2_out_ready;
    logic [127:0] d2_in, d2_out;
    logic         k2_in_valid, k2_in_ready, k2_out_valid, k2_out_ready;
    logic [31:0]  k2_in, k2_out, s2_in, s2_out, s2_p1, s2_p2;
    logic         s2_enc;

    always @(posedge clk) begin
        s2_p1 <= sbox_word(s2_in, s2_enc);
        s2_p2 <= s2_p1;
    end
    assign s2_out = s2_p2;

    sbox_share_ctrl #(.SBOX_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .data_in_valid(d2_in_valid), .data_in_ready(d2_in_ready), .data_in(d2_in),
        .data_encrypt(d2_enc), .data_out_valid(d2_out_valid),
        .data_out_ready(d2_out_ready), .data_out(d2_out),
        .key_in_valid(k2_in_valid), .key_in_ready(k2_in_ready), .key_in(k2_in),
        .key_out_valid(k2_out_valid), .key_out_ready(k2_out_ready), .key_out(k2_out),
        .sbox_in(s2_in), .sbox_encrypt(s2_enc), .sbox_out(s2_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] word_src;
    logic         exp_key_first;

    initial begin
        rst_n = 1'b0;
        d_in_valid = 1'b1; d_in = '0; d_enc = 1'b1; d_out_ready = 1'b0;
        k_in_valid = 1'b1; k_in = '0; k_out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_in = '0; d2_enc = 1'b1; d2_out_ready = 1'b0;
        k2_in_valid = 1'b0; k2_in = '0; k2_out_ready = 1'b0;
        word_src = INC_STATE;
`ifdef SBOX_SHARE_FAIR_EN
        exp_key_first = 1'b0;
`else
        exp_key_first = 1'b1;
`endif

        // ---- reset state (requests asserted to prove ready stays low) ----
        tick(); tick();
        chk("rst_d_in_ready", d_in_ready, 0);
        chk("rst_k_in_ready", k_in_ready, 0);
        chk("rst_d_out_valid", d_out_valid, 0);
        chk("rst_k_out_valid", k_out_valid, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_k_out", k_out, 0);
        chk("rst_sbox_in", s_in, 0);
        chk("rst_sbox_enc", s_enc, 1);
        d_in_valid = 1'b0; k_in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // ---- forward SubBytes, LAT 0 ----
        d_in = INC_STATE; d_enc = 1'b1; d_out_ready = 1'b1; d_in_valid = 1'b1;
        #1 chk("fwd_accept_ready", d_in_ready, 1);
        tick();
        d_in_valid = 1'b0; d_in = '1; d_enc = 1'b0;   // payload must be registered
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("fwd_beat%0d_sbox_in", b), s_in, word_src[32*b +: 32]);
            chk($sformatf("fwd_beat%0d_enc", b), s_enc, 1);
            chk($sformatf("fwd_beat%0d_dvalid", b), d_out_valid, 0);
            tick();
        end
        chk("fwd_dvalid_T5", d_out_valid, 1);
        chk("fwd_dout", d_out, FWD_EXP);
        tick();
        chk("fwd_dvalid_cleared", d_out_valid, 0);

        // ---- inverse SubBytes ----
        d_in = {16{8'h63}}; d_enc = 1'b0; d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("inv_beat%0d_enc", b), s_enc, 0);
            chk($sformatf("inv_beat%0d_sbox_in", b), s_in, 32'h63636363);
            tick();
        end
        chk("inv_dvalid_T5", d_out_valid, 1);
        chk("inv_dout", d_out, 0);
        tick();

        // ---- simultaneous key/data request, key pending blocks nothing ----
        d_out_ready = 1'b0; k_out_ready = 1'b0;
        k_in = 32'h00000000; k_in_valid = 1'b1;
        d_in = INC_STATE; d_enc = 1'b1; d_in_valid = 1'b1;
        #1 chk("conf1_k_ready", k_in_ready, 1);
        chk("conf1_d_ready", d_in_ready, 0);
        tick();
        k_in_valid = 1'b0; k_in = 32'hFFFFFFFF;
        chk("conf1_T1_d_ready", d_in_ready, 0);
        chk("conf1_T1_kvalid", k_out_valid, 0);
        tick();
        chk("conf1_T2_kvalid", k_out_valid, 1);
        chk("conf1_T2_kout", k_out, 32'h63636363);
        chk("conf1_T2_d_ready", d_in_ready, 1);
        tick();
        d_in_valid = 1'b0;
        chk("conf1_T3_kvalid_held", k_out_valid, 1);
        tick(); tick(); tick();
        chk("conf1_T6_dvalid", d_out_valid, 0);
        tick();
        chk("conf1_T7_dvalid", d_out_valid, 1);
        chk("conf1_T7_dout", d_out, FWD_EXP);
        chk("conf1_T7_kout_held", k_out, 32'h63636363);

        // ---- data output back-pressured 10 cycles, key still served ----
        d_in_valid = 1'b1; d_in = 128'hDEADBEEF_01234567_89ABCDEF_55AA55AA;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: k_out_ready = 1'b1;
                1: begin
                    chk("bp_kvalid_consumed", k_out_valid, 0);
                    k_in = 32'h03020100; k_in_valid = 1'b1;
                    #1 chk("bp_k_ready", k_in_ready, 1);
                end
                2: begin k_in_valid = 1'b0; k_in = 32'h0; end
                3: begin
                    chk("bp_kvalid", k_out_valid, 1);
                    chk("bp_kout", k_out, 32'h7B777C63);
                end
                4: chk("bp_kvalid_cleared", k_out_valid, 0);
                default: ;
            endcase
            chk($sformatf("bp%0d_dvalid", i), d_out_valid, 1);
            chk($sformatf("bp%0d_dout", i), d_out, FWD_EXP);
            chk($sformatf("bp%0d_d_ready", i), d_in_ready, 0);
            tick();
        end
        d_in_valid = 1'b0; d_out_ready = 1'b1;
        tick();
        chk("bp_dvalid_cleared", d_out_valid, 0);

        // ---- second conflict: fixed priority vs round robin ----
        k_in_valid = 1'b1; k_in = 32'h0; d_in_valid = 1'b1; d_in = INC_STATE;
        #1 chk("conf2_k_ready", k_in_ready, exp_key_first);
        chk("conf2_d_ready", d_in_ready, !exp_key_first);
        tick();
        k_in_valid = 1'b0; d_in_valid = 1'b0;
        repeat (8) tick();

        // ---- reset in the middle of a data job ----
        k_out_ready = 1'b0; k_in = 32'h03020100; k_in_valid = 1'b1;
        tick();
        k_in_valid = 1'b0;
        tick();
        chk("mid_kvalid_pending", k_out_valid, 1);
        d_in = INC_STATE; d_enc = 1'b1; d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        tick(); tick();
        chk("mid_beat2_sbox_in", s_in, 32'h0B0A0908);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_kvalid", k_out_valid, 0);
        chk("mid_rst_dvalid", d_out_valid, 0);
        chk("mid_rst_sbox_in", s_in, 0);
        chk("mid_rst_kout", k_out, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("mid_post%0d_dvalid", i), d_out_valid, 0);
        end
        chk("mid_post_dout", d_out, 0);

        // ---- SBOX_LAT = 2 ----
        d2_in = INC_STATE; d2_enc = 1'b1; d2_out_ready = 1'b1; k2_out_ready = 1'b1;
        d2_in_valid = 1'b1;
        #1 chk("lat2_d_ready", d2_in_ready, 1);
        tick();
        d2_in_valid = 1'b0; d2_in = '1;
        repeat (5) tick();
        chk("lat2_dvalid_T6", d2_out_valid, 0);
        tick();
        chk("lat2_dvalid_T7", d2_out_valid, 1);
        chk("lat2_dout", d2_out, FWD_EXP);
        k2_in = 32'h03020100; k2_in_valid = 1'b1;
        #1 chk("lat2_k_ready", k2_in_ready, 1);
        tick();
        k2_in_valid = 1'b0;
        tick(); tick();
        chk("lat2_kvalid_T3", k2_out_valid, 0);
        tick();
        chk("lat2_kvalid_T4", k2_out_valid, 1);
        chk("lat2_kout", k2_out, 32'h7B777C63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_share_ctrl.md
SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

Interface
REQ-001 Parameter SBOX_LAT, default 0: register stages inside the external 4-lane shared S-box, legal 0..2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 data_in_valid / data_in_ready  input / output  1 / 1  round-datapath SubBytes request handshake.
REQ-005 data_in  input  128  state bytes; byte i = data_in[8i+7:8i].
REQ-006 data_encrypt  input  1  1 = forward S-box, 0 = inverse; sampled at accept.
REQ-007 data_out_valid / data_out_ready  output / input  1 / 1  SubBytes result handshake.
REQ-008 data_out  output  128  substituted state, same byte order.
REQ-009 key_in_valid / key_in_ready  input / output  1 / 1  key-expansion SubWord request handshake.
REQ-010 key_in  input  32  word to substitute.
REQ-011 key_out_valid / key_out_ready, key_out  output / input, output  1 / 1, 32  SubWord result.
REQ-012 sbox_in  output  32  lane inputs to shared S-box, lane j = bits [8j+7:8j].
REQ-013 sbox_encrypt  output  1  mode to all lanes.
REQ-014 sbox_out  input  32  lane results, valid SBOX_LAT cycles after sbox_in.

Function
REQ-015 FSM states IDLE, ISSUE, DRAIN; ISSUE holds 2-bit beat counter.
REQ-016 Requester eligible only when its valid is high and its output buffer empty (out_valid low).
REQ-017 Grant only in IDLE; key_in_ready/data_in_ready high combinationally for the granted requester only; accept = valid && ready.
REQ-018 Both eligible in same cycle: key wins (fixed priority) unless SBOX_SHARE_FAIR_EN (REQ-031).
REQ-019 Data job accepted cycle T: ISSUE beats b=0..3 at T+1..T+4, sbox_in = bytes 4b..4b+3; key job: single beat at T+1, sbox_in = key_in.
REQ-020 Request payload and mode registered at accept; requester may change inputs after accept.
REQ-021 sbox_encrypt = registered data_encrypt for data jobs, 1 for key jobs, 1 when idle; sbox_in = 0 when no beat issues.
REQ-022 Result of beat b captured from sbox_out at beat cycle + SBOX_LAT into the matching output slice.
REQ-023 DRAIN lasts SBOX_LAT cycles (skipped when 0); return to IDLE after last capture.
REQ-024 data_out_valid rises at T+5+SBOX_LAT; key_out_valid at T+2+SBOX_LAT.
REQ-025 Output valid and payload held stable until out_ready; clears the cycle after handshake.
REQ-026 New grant possible in the cycle FSM re-enters IDLE; pending output of one requester never blocks the other.
REQ-027 out_ready ignored while out_valid low; in_valid dropping before accept is legal, no job started.
REQ-028 No preemption: a granted job completes all beats before any other grant.

Reset
REQ-029 rst_n low: FSM IDLE, beat counter 0, all out_valid 0, data_out/key_out 0, in_ready 0, sbox_in 0, sbox_encrypt 1, priority pointer to key.
REQ-030 Reset mid-job discards job; no result is produced after release.

Configuration
REQ-031 SBOX_SHARE_FAIR_EN defined: round-robin on simultaneous eligibility, pointer toggles to other requester after each grant; undefined: fixed key priority, no pointer state.

Verification
REQ-032 SBOX_LAT=0, data_in=00..0F bytes, encrypt=1, out_ready=1 -> data_out bytes 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76 at T+5.
REQ-033 Same with encrypt=0, data_in all 63 -> data_out all 00; sbox_encrypt low during beats.
REQ-034 Key and data valid same cycle, key_in=00000000 -> key granted first, key_out=63636363 at T+2, data accepted at T+2 (fixed) / alternation over two conflicts with FAIR_EN.
REQ-035 data_out_ready held low 10 cycles -> data_out stable, data_in_ready low, key job still served.
REQ-036 rst_n asserted at beat 2 of data job -> all valids 0 immediately, no data_out_valid after release.
REQ-037 SBOX_LAT=2 -> data_out_valid at T+7, key_out_valid at T+4, results identical to REQ-032.
